// File: rtl/pll_ctrl_pkg.sv
// pll_ctrl_pkg: shared definitions for the PLL lock controller.
//   pll_state_t  - sequencer states
//   SYNC_STAGES  - depth of the pll_lock synchronizer
//   LOSS_W       - width of the saturating lock-loss counter
//   max3()       - helper used to size the shared phase counter
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    RESET_HOLD,
    WAIT_LOCK,
    SETTLE,
    RUN,
    FAIL
  } pll_state_t;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned LOSS_W      = 8;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_lock_ctrl_sync_2ff.sv
// sync_2ff: multi-flop synchronizer for a single asynchronous bit.
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset (chain clears to 0)
//   d_i   - asynchronous input
//   q_o   - synchronized output, STAGES cycles of latency
module sync_2ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_ctrl.sv
// pll_lock_ctrl: sequencer for the iCE40UP PLL primitive. Pulses the PLL
// reset, waits for a stable LOCK, qualifies the output clock, recovers from
// lock loss and gives up after MAX_RETRIES failed attempts.
// Optional feature macro: PLL_LOCK_CTRL_DELAY_EN adds the dynamic-delay
// request port group (dly_req/dly_val/dly_ack) with re-qualification.
// Ports:
//   clk, rst_n  - free-running controller clock, async active-low reset
//   pll_lock    - PLL LOCK (asynchronous, synchronized internally)
//   restart     - one-cycle pulse forcing a fresh sequence
//   pll_resetb  - PLL RESET (active low)
//   pll_bypass  - PLL BYPASS (only in FAIL when FAIL_BYPASS)
//   pll_delay   - PLL DYNAMICDELAY
//   clk_ok      - PLL output qualified
//   fail        - retries exhausted
//   retry_cnt   - failed attempts in the current sequence
//   loss_cnt    - lock losses seen in RUN, saturating
//   dly_req/dly_val/dly_ack - delay change handshake (macro only)
module pll_lock_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 4096,
  parameter int unsigned SETTLE_CYCLES = 256,
  parameter int unsigned MAX_RETRIES   = 3,
  parameter logic [3:0]  DELAY_INIT    = 4'd0,
  parameter bit          FAIL_BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pll_lock,
  input  logic              restart,
  output logic              pll_resetb,
  output logic              pll_bypass,
  output logic [3:0]        pll_delay,
  output logic              clk_ok,
  output logic              fail,
  output logic [1:0]        retry_cnt,
  output logic [LOSS_W-1:0] loss_cnt
`ifdef PLL_LOCK_CTRL_DELAY_EN
  ,
  input  logic              dly_req,
  input  logic [3:0]        dly_val,
  output logic              dly_ack
`endif
);

  localparam int unsigned CNT_MAX = max3(RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  pll_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        retry_q, retry_d;
  logic [LOSS_W-1:0] loss_q, loss_d;
  logic              resetb_q, resetb_d;
  logic              bypass_q, bypass_d;
  logic              clk_ok_q, clk_ok_d;
  logic              fail_q, fail_d;
  logic              lock_s;

`ifdef PLL_LOCK_CTRL_DELAY_EN
  logic [3:0]        delay_q, delay_d;
  logic              pend_q, pend_d;
  logic              ack_q, ack_d;
`endif

  sync_2ff #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (pll_lock),
    .q_o   (lock_s)
  );

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    loss_d  = loss_q;
`ifdef PLL_LOCK_CTRL_DELAY_EN
    delay_d = delay_q;
    pend_d  = pend_q;
    ack_d   = 1'b0;
`endif

    case (state_q)
      RESET_HOLD: begin
        if (cnt_q == CNT_W'(RST_CYCLES - 1)) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = SETTLE;
        end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
          retry_d = retry_q + 2'd1;
          state_d = (retry_d == 2'(MAX_RETRIES)) ? FAIL : RESET_HOLD;
        end
      end
      SETTLE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          state_d = RUN;
          retry_d = '0;
        end
      end
      RUN: begin
        if (!lock_s) begin
          loss_d  = (loss_q == '1) ? loss_q : loss_q + 1'b1;
          state_d = RESET_HOLD;
        end
`ifdef PLL_LOCK_CTRL_DELAY_EN
        // The ack cycle is excluded so a requester still holding dly_req
        // while it sees dly_ack does not launch a second change.
        else if (dly_req && !ack_q) begin
          delay_d = dly_val;
          pend_d  = 1'b1;
          state_d = SETTLE;
        end
`endif
      end
      FAIL:    state_d = FAIL;
      default: state_d = RESET_HOLD;
    endcase

    // restart wins over anything decided above, including a loss count
    // or a delay acceptance in the same cycle.
    if (restart) begin
      state_d = RESET_HOLD;
      retry_d = '0;
      loss_d  = loss_q;
`ifdef PLL_LOCK_CTRL_DELAY_EN
      delay_d = delay_q;
      pend_d  = pend_q;
`endif
    end

`ifdef PLL_LOCK_CTRL_DELAY_EN
    if (pend_q && state_d == RUN && state_q != RUN) begin
      ack_d  = 1'b1;
      pend_d = 1'b0;
    end
`endif

    if (restart || state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q inside {RESET_HOLD, WAIT_LOCK, SETTLE}) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end

    // Outputs are registered from the next state so they change on the
    // same edge as the state itself.
    resetb_d = state_d inside {WAIT_LOCK, SETTLE, RUN};
    clk_ok_d = (state_d == RUN);
    fail_d   = (state_d == FAIL);
    bypass_d = (state_d == FAIL) && FAIL_BYPASS;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RESET_HOLD;
      cnt_q    <= '0;
      retry_q  <= '0;
      loss_q   <= '0;
      resetb_q <= 1'b0;
      bypass_q <= 1'b0;
      clk_ok_q <= 1'b0;
      fail_q   <= 1'b0;
`ifdef PLL_LOCK_CTRL_DELAY_EN
      delay_q  <= DELAY_INIT;
      pend_q   <= 1'b0;
      ack_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      retry_q  <= retry_d;
      loss_q   <= loss_d;
      resetb_q <= resetb_d;
      bypass_q <= bypass_d;
      clk_ok_q <= clk_ok_d;
      fail_q   <= fail_d;
`ifdef PLL_LOCK_CTRL_DELAY_EN
      delay_q  <= delay_d;
      pend_q   <= pend_d;
      ack_q    <= ack_d;
`endif
    end
  end

  assign pll_resetb = resetb_q;
  assign pll_bypass = bypass_q;
  assign clk_ok     = clk_ok_q;
  assign fail       = fail_q;
  assign retry_cnt  = retry_q;
  assign loss_cnt   = loss_q;
`ifdef PLL_LOCK_CTRL_DELAY_EN
  assign pll_delay  = delay_q;
  assign dly_ack    = ack_q;
`else
  assign pll_delay  = DELAY_INIT;
`endif

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// tb_pll_lock_ctrl: self-checking bench for pll_lock_ctrl. Expected event
// cycles are queued when stimulus is applied and compared when the DUT
// output changes. Shortened timeout/settle parameters keep runtime small.
// Delay-request scenario is compiled in when PLL_LOCK_CTRL_DELAY_EN is set.
module tb_pll_lock_ctrl;

  localparam int unsigned RST = 16;
  localparam int unsigned TO  = 200;
  localparam int unsigned SET = 40;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_lock = 1'b0;
  logic       restart = 1'b0;
  logic       pll_resetb, pll_bypass, clk_ok, fail;
  logic [3:0] pll_delay;
  logic [1:0] retry_cnt;
  logic [7:0] loss_cnt;
`ifdef PLL_LOCK_CTRL_DELAY_EN
  logic       dly_req = 1'b0;
  logic [3:0] dly_val = 4'd0;
  logic       dly_ack;
`endif

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];
  int exp_loss = 0;

  pll_lock_ctrl #(
    .RST_CYCLES    (RST),
    .LOCK_TIMEOUT  (TO),
    .SETTLE_CYCLES (SET),
    .MAX_RETRIES   (3),
    .DELAY_INIT    (4'd0),
    .FAIL_BYPASS   (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_lock   (pll_lock),
    .restart    (restart),
    .pll_resetb (pll_resetb),
    .pll_bypass (pll_bypass),
    .pll_delay  (pll_delay),
    .clk_ok     (clk_ok),
    .fail       (fail),
    .retry_cnt  (retry_cnt),
    .loss_cnt   (loss_cnt)
`ifdef PLL_LOCK_CTRL_DELAY_EN
    ,
    .dly_req    (dly_req),
    .dly_val    (dly_val),
    .dly_ack    (dly_ack)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sig(input int which);
    case (which)
      0: return pll_resetb;
      1: return clk_ok;
      2: return fail;
`ifdef PLL_LOCK_CTRL_DELAY_EN
      3: return dly_ack;
`endif
      default: return 1'bx;
    endcase
  endfunction

  // Returns the cycle at which the signal first holds val, or -1 on timeout.
  task automatic wait_sig(input int which, input logic val, input int limit, output int at);
    at = -1;
    for (int i = 0; i <= limit && at < 0; i++) begin
      if (sig(which) === val) at = cyc;
      else tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if ({pll_resetb, pll_bypass, clk_ok, fail} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_flags: got %b expected 0000", {pll_resetb, pll_bypass, clk_ok, fail});
    end
    n_cmp++;
    if (retry_cnt !== 2'd0) begin
      n_err++; $display("FAIL reset_retry: got %0d expected 0", retry_cnt);
    end
    n_cmp++;
    if (loss_cnt !== 8'd0) begin
      n_err++; $display("FAIL reset_loss: got %0d expected 0", loss_cnt);
    end
    n_cmp++;
    if (pll_delay !== 4'd0) begin
      n_err++; $display("FAIL reset_delay: got %0d expected 0", pll_delay);
    end
  endtask

  task automatic test_nominal();
    int c0, at, e;
    c0 = cyc;
    rst_n = 1'b1;
    exp_q.push_back(c0 + RST);
    wait_sig(0, 1'b1, RST + 10, at);
    e = exp_q.pop_front();
    n_cmp++;
    if (at !== e) begin
      n_err++; $display("FAIL nom_resetb_rise: got cycle %0d expected %0d", at, e);
    end
    repeat (100) tick();
    c0 = cyc;
    pll_lock = 1'b1;
    exp_q.push_back(c0 + 3 + SET);
    wait_sig(1, 1'b1, SET + 20, at);
    e = exp_q.pop_front();
    n_cmp++;
    if (at !== e) begin
      n_err++; $display("FAIL nom_clk_ok_rise: got cycle %0d expected %0d", at, e);
    end
    n_cmp++;
    if (retry_cnt !== 2'd0) begin
      n_err++; $display("FAIL nom_retry: got %0d expected 0", retry_cnt);
    end
  endtask

  task automatic test_settle_glitch();
    int r, w, g, at, e;
    r = cyc;
    restart = 1'b1;
    pll_lock = 1'b0;
    tick();
    restart = 1'b0;
    n_cmp++;
    if ({clk_ok, pll_resetb} !== 2'b00) begin
      n_err++; $display("FAIL restart_outputs: got %b expected 00", {clk_ok, pll_resetb});
    end
    exp_q.push_back(r + 1 + RST);
    wait_sig(0, 1'b1, RST + 10, at);
    e = exp_q.pop_front();
    n_cmp++;
    if (at !== e) begin
      n_err++; $display("FAIL restart_resetb_rise: got cycle %0d expected %0d", at, e);
    end
    w = cyc;
    pll_lock = 1'b1;
    while (cyc < w + 3 + 20) tick();
    g = cyc;
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    exp_q.push_back(g + 4 + SET);
    wait_sig(1, 1'b1, SET + 30, at);
    e = exp_q.pop_front();
    n_cmp++;
    if (at !== e) begin
      n_err++; $display("FAIL glitch_clk_ok_rise: got cycle %0d expected %0d", at, e);
    end
    n_cmp++;
    if (retry_cnt !== 2'd0 || loss_cnt !== 8'(exp_loss)) begin
      n_err++;
      $display("FAIL glitch_counters: got retry %0d loss %0d expected retry 0 loss %0d", retry_cnt, loss_cnt, exp_loss);
    end
  endtask

  task automatic test_timeout_fail();
    int f, t, at, e;
    f = cyc;
    pll_lock = 1'b0;
    if (exp_loss < 255) exp_loss++;
    exp_q.push_back(f + 3);
    wait_sig(1, 1'b0, 10, at);
    e = exp_q.pop_front();
    n_cmp++;
    if (at !== e || pll_resetb !== 1'b0) begin
      n_err++; $display("FAIL loss_clk_ok_fall: got cycle %0d resetb %b expected cycle %0d resetb 0", at, pll_resetb, e);
    end
    t = f + 3;
    for (int k = 1; k <= 3; k++) begin
      exp_q.push_back(t + RST);
      exp_q.push_back(t + RST + TO);
      wait_sig(0, 1'b1, RST + 5, at);
      e = exp_q.pop_front();
      n_cmp++;
      if (at !== e) begin
        n_err++; $display("FAIL to_resetb_rise%0d: got cycle %0d expected %0d", k, at, e);
      end
      wait_sig(0, 1'b0, TO + 5, at);
      e = exp_q.pop_front();
      n_cmp++;
      if (at !== e) begin
        n_err++; $display("FAIL to_timeout%0d: got cycle %0d expected %0d", k, at, e);
      end
      n_cmp++;
      if (retry_cnt !== 2'(k) || fail !== (k == 3)) begin
        n_err++; $display("FAIL to_retry%0d: got retry %0d fail %b expected retry %0d fail %b", k, retry_cnt, fail, k, (k == 3));
      end
      t = t + RST + TO;
    end
    n_cmp++;
    if (pll_bypass !== 1'b1) begin
      n_err++; $display("FAIL fail_bypass: got %b expected 1", pll_bypass);
    end
    repeat (50) tick();
    n_cmp++;
    if ({fail, pll_resetb, pll_bypass} !== 3'b101) begin
      n_err++; $display("FAIL fail_hold: got %b expected 101", {fail, pll_resetb, pll_bypass});
    end
    n_cmp++;
    if (loss_cnt !== 8'(exp_loss)) begin
      n_err++; $display("FAIL to_loss: got %0d expected %0d", loss_cnt, exp_loss);
    end
  endtask

  task automatic test_restart_from_fail();
    int x, at, e;
    x = cyc;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    n_cmp++;
    if ({fail, pll_bypass, retry_cnt} !== 4'b0000) begin
      n_err++; $display("FAIL restart_clear: got fail %b bypass %b retry %0d expected 0 0 0", fail, pll_bypass, retry_cnt);
    end
    exp_q.push_back(x + 1 + RST);
    wait_sig(0, 1'b1, RST + 5, at);
    e = exp_q.pop_front();
    n_cmp++;
    if (at !== e) begin
      n_err++; $display("FAIL restart_fail_rise: got cycle %0d expected %0d", at, e);
    end
  endtask

  task automatic test_restart_at_timeout();
    int r, at, e;
    r = cyc;
    for (int k = 1; k <= 2; k++) begin
      exp_q.push_back(r + TO);
      exp_q.push_back(r + TO + RST);
      wait_sig(0, 1'b0, TO + 5, at);
      e = exp_q.pop_front();
      n_cmp++;
      if (at !== e) begin
        n_err++; $display("FAIL rt_timeout%0d: got cycle %0d expected %0d", k, at, e);
      end
      wait_sig(0, 1'b1, RST + 5, at);
      e = exp_q.pop_front();
      n_cmp++;
      if (at !== e) begin
        n_err++; $display("FAIL rt_rise%0d: got cycle %0d expected %0d", k, at, e);
      end
      r = at;
    end
    n_cmp++;
    if (retry_cnt !== 2'd2) begin
      n_err++; $display("FAIL rt_retry_before: got %0d expected 2", retry_cnt);
    end
    while (cyc < r + TO - 1) tick();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    n_cmp++;
    if ({retry_cnt, fail, pll_resetb} !== 4'b0000) begin
      n_err++; $display("FAIL rt_collision: got retry %0d fail %b resetb %b expected 0 0 0", retry_cnt, fail, pll_resetb);
    end
    exp_q.push_back(r + TO + RST);
    wait_sig(0, 1'b1, RST + 5, at);
    e = exp_q.pop_front();
    n_cmp++;
    if (at !== e || fail !== 1'b0) begin
      n_err++; $display("FAIL rt_rise_after: got cycle %0d fail %b expected cycle %0d fail 0", at, fail, e);
    end
  endtask

  task automatic test_loss_saturation();
    int f, at, e;
    pll_lock = 1'b1;
    wait_sig(1, 1'b1, SET + 10, at);
    n_cmp++;
    if (at < 0) begin
      n_err++; $display("FAIL sat_initial_lock: got timeout expected clk_ok high");
    end
    for (int i = 0; i < 300; i++) begin
      f = cyc;
      pll_lock = 1'b0;
      if (exp_loss < 255) exp_loss++;
      exp_q.push_back(f + 3);
      exp_q.push_back(f + 3 + RST);
      wait_sig(1, 1'b0, 10, at);
      e = exp_q.pop_front();
      n_cmp++;
      if (at !== e) begin
        n_err++; $display("FAIL sat_clk_ok_fall%0d: got cycle %0d expected %0d", i, at, e);
      end
      pll_lock = 1'b1;
      wait_sig(0, 1'b1, RST + 5, at);
      e = exp_q.pop_front();
      n_cmp++;
      if (at !== e) begin
        n_err++; $display("FAIL sat_resetb_rise%0d: got cycle %0d expected %0d", i, at, e);
      end
      n_cmp++;
      if (loss_cnt !== 8'(exp_loss)) begin
        n_err++; $display("FAIL sat_loss%0d: got %0d expected %0d", i, loss_cnt, exp_loss);
      end
      wait_sig(1, 1'b1, SET + 10, at);
      n_cmp++;
      if (at < 0) begin
        n_err++; $display("FAIL sat_relock%0d: got timeout expected clk_ok high", i);
      end
    end
  endtask

`ifdef PLL_LOCK_CTRL_DELAY_EN
  task automatic test_delay();
    int d, at, e;
    d = cyc;
    dly_req = 1'b1;
    dly_val = 4'd9;
    tick();
    n_cmp++;
    if (pll_delay !== 4'd9 || clk_ok !== 1'b0 || dly_ack !== 1'b0) begin
      n_err++; $display("FAIL dly_apply: got delay %0d clk_ok %b ack %b expected 9 0 0", pll_delay, clk_ok, dly_ack);
    end
    exp_q.push_back(d + 1 + SET);
    wait_sig(3, 1'b1, SET + 10, at);
    e = exp_q.pop_front();
    n_cmp++;
    if (at !== e || clk_ok !== 1'b1) begin
      n_err++; $display("FAIL dly_ack_time: got cycle %0d clk_ok %b expected cycle %0d clk_ok 1", at, clk_ok, e);
    end
    dly_req = 1'b0;
    tick();
    n_cmp++;
    if (dly_ack !== 1'b0 || clk_ok !== 1'b1 || pll_delay !== 4'd9) begin
      n_err++; $display("FAIL dly_after: got ack %b clk_ok %b delay %0d expected 0 1 9", dly_ack, clk_ok, pll_delay);
    end
  endtask
`endif

  task automatic test_async_reset();
    int c0, at, e;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    exp_loss = 0;
    #1;
    n_cmp++;
    if ({clk_ok, pll_resetb, fail, retry_cnt} !== 5'b00000 || loss_cnt !== 8'd0 || pll_delay !== 4'd0) begin
      n_err++;
      $display("FAIL async_clear: got clk_ok %b resetb %b fail %b retry %0d loss %0d delay %0d expected all 0",
               clk_ok, pll_resetb, fail, retry_cnt, loss_cnt, pll_delay);
    end
    tick();
    tick();
    c0 = cyc;
    rst_n = 1'b1;
    exp_q.push_back(c0 + RST);
    exp_q.push_back(c0 + RST + 1 + SET);
    wait_sig(0, 1'b1, RST + 5, at);
    e = exp_q.pop_front();
    n_cmp++;
    if (at !== e) begin
      n_err++; $display("FAIL async_resetb_rise: got cycle %0d expected %0d", at, e);
    end
    wait_sig(1, 1'b1, SET + 10, at);
    e = exp_q.pop_front();
    n_cmp++;
    if (at !== e) begin
      n_err++; $display("FAIL async_clk_ok_rise: got cycle %0d expected %0d", at, e);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_settle_glitch();
    test_timeout_fail();
    test_restart_from_fail();
    test_restart_at_timeout();
    test_loss_saturation();
`ifdef PLL_LOCK_CTRL_DELAY_EN
    test_delay();
`endif
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
